// File: rtl/pe_result_collector.sv
// rtl/pe_result_collector.sv - PE result window collector with FWFT FIFO and checksum
//
// Purpose:
//   Follows the M216A PE output stream for one run. It drops the
//   function-dependent pipeline-fill samples, then captures RUN_LEN results
//   into a first-word-fall-through FIFO. It also keeps a 32-bit running
//   checksum of the captured window.
//
// Ports:
//   Clk_In          in   1   clock, rising edge
//   Rst_In          in   1   synchronous active-high reset
//   Instruction_In  in  16   PE function code, latched on Start_In
//   Start_In        in   1   first cycle of a new PE run (sample index 0)
//   D_Out_In        in  16   PE D_Out stream
//   Res_Data        out 16   FIFO head (0 when empty)
//   Res_Valid       out  1   FIFO not empty
//   Res_Ready       in   1   consumer pops head when Res_Valid
//   Busy            out  1   in FILL or CAPTURE
//   Done            out  1   window complete, held until Start_In/reset
//   Checksum        out 32   sum of in-window samples, mod 2^32
//   Overflow        out  1   sticky, an in-window sample was dropped
//   Err_Out         out  1   sticky, Start_In with an unsupported code

module pe_result_collector #(
    parameter int RUN_LEN    = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        Clk_In,
    input  logic        Rst_In,
    input  logic [15:0] Instruction_In,
    input  logic        Start_In,
    input  logic [15:0] D_Out_In,
    output logic [15:0] Res_Data,
    output logic        Res_Valid,
    input  logic        Res_Ready,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Checksum,
    output logic        Overflow,
    output logic        Err_Out
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // idx is the index of the sample presented at the coming edge
    logic [8:0]  idx;
    logic [2:0]  lat_q;
    logic [2:0]  start_lat;
    logic        start_ok;
    logic [8:0]  fill_last;
    logic [8:0]  capture_last;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          in_window;
    logic          push;

    logic [31:0] checksum_q;
    logic        overflow_q;
    logic        err_q;

    // Pipeline-fill latency per PE function code; 0 marks unsupported codes.
    always_comb begin
        start_lat = 3'd0;
        start_ok  = 1'b0;
        case (Instruction_In)
            16'd1, 16'd3, 16'd4, 16'd5, 16'd6: begin
                start_lat = 3'd2;
                start_ok  = 1'b1;
            end
            16'd2, 16'd7: begin
                start_lat = 3'd4;
                start_ok  = 1'b1;
            end
            16'd8: begin
                start_lat = 3'd6;
                start_ok  = 1'b1;
            end
            default: begin
                start_lat = 3'd0;
                start_ok  = 1'b0;
            end
        endcase
    end

    assign fill_last    = {6'd0, lat_q} - 9'd1;
    assign capture_last = {6'd0, lat_q} + 9'(RUN_LEN) - 9'd1;

    // FIFO handshake. A restart flushes the FIFO, so the sample at the Start_In
    // edge is never captured and any pop in that cycle is lost to the flush.
    assign full      = (count == (AW + 1)'(FIFO_DEPTH));
    assign Res_Valid = (count != '0);
    assign pop       = Res_Valid & Res_Ready;
    assign in_window = (state == S_CAPTURE) & ~Start_In;
    assign push      = in_window & (~full | pop);
    assign Res_Data  = Res_Valid ? mem[rd_ptr] : 16'd0;

    // State register
    always_ff @(posedge Clk_In) begin
        if (Rst_In) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; Start_In wins from every state
    always_comb begin
        state_next = state;
        if (Start_In) begin
            state_next = start_ok ? S_FILL : S_IDLE;
        end else begin
            case (state)
                S_FILL: begin
                    if (idx == fill_last) begin
                        state_next = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (idx == capture_last) begin
                        state_next = S_DONE;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    // Sample index and latched latency. Index 0 is consumed on the Start_In
    // edge itself, so the counter restarts at 1.
    always_ff @(posedge Clk_In) begin
        if (Rst_In) begin
            idx   <= 9'd0;
            lat_q <= 3'd0;
        end else if (Start_In) begin
            idx   <= 9'd1;
            lat_q <= start_lat;
        end else if ((state == S_FILL) || (state == S_CAPTURE)) begin
            idx <= idx + 9'd1;
        end
    end

    // FIFO storage is not reset; occupancy gates its visibility.
    always_ff @(posedge Clk_In) begin
        if (push) begin
            mem[wr_ptr] <= D_Out_In;
        end
    end

    always_ff @(posedge Clk_In) begin
        if (Rst_In || Start_In) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Checksum covers every in-window sample, including ones dropped on overflow.
    always_ff @(posedge Clk_In) begin
        if (Rst_In) begin
            checksum_q <= 32'd0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (Start_In) begin
            checksum_q <= 32'd0;
            overflow_q <= 1'b0;
            err_q      <= ~start_ok;
        end else begin
            if (in_window) begin
                checksum_q <= checksum_q + {16'd0, D_Out_In};
            end
            if (in_window && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign Checksum = checksum_q;
    assign Overflow = overflow_q;
    assign Err_Out  = err_q;
    assign Busy     = (state == S_FILL) || (state == S_CAPTURE);
    assign Done     = (state == S_DONE);

endmodule

// File: tb/tb_pe_result_collector.sv
// tb/tb_pe_result_collector.sv - self-checking bench for pe_result_collector

module tb_pe_result_collector;

    localparam int A_RUN   = 8;
    localparam int A_DEPTH = 4;

    logic        Clk_In = 1'b0;
    logic        Rst_In = 1'b1;
    logic [15:0] Instruction_In = 16'd0;
    logic        Start_In = 1'b0;
    logic [15:0] D_Out_In = 16'd0;
    logic        Res_Ready = 1'b0;

    logic [15:0] Res_Data_a, Res_Data_b;
    logic        Res_Valid_a, Res_Valid_b;
    logic        Busy_a, Busy_b, Done_a, Done_b;
    logic [31:0] Checksum_a, Checksum_b;
    logic        Overflow_a, Overflow_b, Err_a, Err_b;

    pe_result_collector #(.RUN_LEN(A_RUN), .FIFO_DEPTH(A_DEPTH)) dut_a (
        .Clk_In(Clk_In), .Rst_In(Rst_In), .Instruction_In(Instruction_In),
        .Start_In(Start_In), .D_Out_In(D_Out_In), .Res_Data(Res_Data_a),
        .Res_Valid(Res_Valid_a), .Res_Ready(Res_Ready), .Busy(Busy_a),
        .Done(Done_a), .Checksum(Checksum_a), .Overflow(Overflow_a), .Err_Out(Err_a)
    );

    pe_result_collector #(.RUN_LEN(5), .FIFO_DEPTH(8)) dut_b (
        .Clk_In(Clk_In), .Rst_In(Rst_In), .Instruction_In(Instruction_In),
        .Start_In(Start_In), .D_Out_In(D_Out_In), .Res_Data(Res_Data_b),
        .Res_Valid(Res_Valid_b), .Res_Ready(Res_Ready), .Busy(Busy_b),
        .Done(Done_b), .Checksum(Checksum_b), .Overflow(Overflow_b), .Err_Out(Err_b)
    );

    always #5 Clk_In = ~Clk_In;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] got[$];
    logic [15:0] got_b[$];

    // Reference model for dut_a: run phase, sample position, result queue
    int          m_phase = 0;   // 0 idle, 1 running, 2 done
    int          m_k = 0;
    int          m_L = 0;
    logic [15:0] m_q[$];
    logic [31:0] m_sum = 0;
    bit          m_ovf = 0;
    bit          m_err = 0;

    typedef struct {
        logic [15:0]         code;
        logic [0:15][15:0]   d;
        logic [0:7][15:0]    exp;
        int                  n_exp;
        logic [31:0]         sum;
        bit                  use_b;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [15:0] c);
        if (c == 1 || c == 3 || c == 4 || c == 5 || c == 6) return 2;
        if (c == 2 || c == 7) return 4;
        if (c == 8) return 6;
        return 0;
    endfunction

    task automatic model_update(input bit rst, input bit st, input logic [15:0] ins,
                                input logic [15:0] d, input bit rdy);
        bit p;
        if (rst) begin
            m_q.delete();
            m_phase = 0; m_sum = 0; m_ovf = 0; m_err = 0;
        end else begin
            p = (m_q.size() > 0) && rdy;
            if (st) begin
                m_q.delete();
                m_sum = 0; m_ovf = 0; m_err = 0;
                m_L = lat_of(ins);
                if (m_L == 0) begin
                    m_err = 1; m_phase = 0;
                end else begin
                    m_phase = 1; m_k = 1;
                end
            end else begin
                if (p) void'(m_q.pop_front());
                if (m_phase == 1) begin
                    if (m_k >= m_L) begin
                        m_sum = m_sum + 32'(d);
                        if (m_q.size() < A_DEPTH) m_q.push_back(d);
                        else m_ovf = 1;
                    end
                    m_k++;
                    if (m_k == m_L + A_RUN) m_phase = 2;
                end
            end
        end
    endtask

    task automatic model_compare();
        chk("valid", Res_Valid_a, m_q.size() > 0);
        if (m_q.size() > 0) chk("data", Res_Data_a, m_q[0]);
        chk("busy", Busy_a, m_phase == 1);
        chk("done", Done_a, m_phase == 2);
        chk("checksum", Checksum_a, m_sum);
        chk("overflow", Overflow_a, m_ovf);
        chk("err", Err_a, m_err);
    endtask

    // Drive one cycle: record pops that happen at the coming edge, clock,
    // advance the model, then compare 1 time unit after the edge.
    task automatic step(input bit rst, input bit st, input logic [15:0] ins,
                        input logic [15:0] d, input bit rdy);
        Rst_In = rst; Start_In = st; Instruction_In = ins; D_Out_In = d; Res_Ready = rdy;
        if (!rst && !st) begin
            if (Res_Valid_a && rdy) got.push_back(Res_Data_a);
            if (Res_Valid_b && rdy) got_b.push_back(Res_Data_b);
        end
        @(posedge Clk_In);
        model_update(rst, st, ins, d, rdy);
        #1;
        model_compare();
    endtask

    initial begin
        // Directed vectors from the test plan
        vecs[0].code = 16'd1; vecs[0].n_exp = 8; vecs[0].sum = 32'd36;  vecs[0].use_b = 0;
        vecs[1].code = 16'd2; vecs[1].n_exp = 8; vecs[1].sum = 32'd36;  vecs[1].use_b = 0;
        vecs[2].code = 16'd3; vecs[2].n_exp = 8; vecs[2].sum = 32'd152; vecs[2].use_b = 0;
        vecs[3].code = 16'd8; vecs[3].n_exp = 5; vecs[3].sum = 32'd370; vecs[3].use_b = 1;
        for (int i = 0; i < 16; i++) begin
            vecs[0].d[i] = (i < 2) ? 16'd0 : 16'(i - 1);
            vecs[1].d[i] = (i < 4) ? 16'd0 : 16'(i - 3);
            vecs[2].d[i] = (i < 2) ? 16'd0 : 16'(12 + 2 * (i - 2));
            vecs[3].d[i] = 16'd0;
        end
        vecs[3].d[6] = 16'd12; vecs[3].d[7] = 16'd32; vecs[3].d[8] = 16'd62;
        vecs[3].d[9] = 16'd104; vecs[3].d[10] = 16'd160;
        for (int j = 0; j < 8; j++) begin
            vecs[0].exp[j] = 16'(j + 1);
            vecs[1].exp[j] = 16'(j + 1);
            vecs[2].exp[j] = 16'(12 + 2 * j);
            vecs[3].exp[j] = 16'd0;
        end
        vecs[3].exp[0] = 16'd12; vecs[3].exp[1] = 16'd32; vecs[3].exp[2] = 16'd62;
        vecs[3].exp[3] = 16'd104; vecs[3].exp[4] = 16'd160;

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_data", Res_Data_a, 0);
        chk("rst_valid", Res_Valid_a, 0);
        chk("rst_busy", Busy_a, 0);
        chk("rst_done", Done_a, 0);
        chk("rst_cks", Checksum_a, 0);
        step(0, 0, 0, 0, 0);

        // Table-driven functions, consumer always ready
        for (int v = 0; v < 4; v++) begin
            got.delete(); got_b.delete();
            step(0, 1, vecs[v].code, vecs[v].d[0], 1);
            chk("start_busy", vecs[v].use_b ? Busy_b : Busy_a, 1);
            for (int i = 1; i < 16; i++) step(0, 0, vecs[v].code, vecs[v].d[i], 1);
            if (vecs[v].use_b) begin
                chk("vec_count", got_b.size(), vecs[v].n_exp);
                for (int j = 0; j < vecs[v].n_exp && j < got_b.size(); j++)
                    chk("vec_data", got_b[j], vecs[v].exp[j]);
                chk("vec_cks", Checksum_b, vecs[v].sum);
                chk("vec_done", Done_b, 1);
                chk("vec_ovf", Overflow_b, 0);
            end else begin
                chk("vec_count", got.size(), vecs[v].n_exp);
                for (int j = 0; j < vecs[v].n_exp && j < got.size(); j++)
                    chk("vec_data", got[j], vecs[v].exp[j]);
                chk("vec_cks", Checksum_a, vecs[v].sum);
                chk("vec_done", Done_a, 1);
                chk("vec_ovf", Overflow_a, 0);
            end
        end

        // Overflow: depth 4, consumer stalled, function 1 stream
        step(0, 1, 1, 0, 0);
        for (int i = 1; i < 14; i++) step(0, 0, 1, (i < 2) ? 16'd0 : 16'(i - 1), 0);
        chk("ovf_flag", Overflow_a, 1);
        chk("ovf_cks", Checksum_a, 36);
        chk("ovf_head", Res_Data_a, 1);
        chk("ovf_done", Done_a, 1);
        got.delete();
        for (int i = 0; i < 6; i++) step(0, 0, 1, 16'd0, 1);
        chk("drain_count", got.size(), 4);
        for (int j = 0; j < 4 && j < got.size(); j++) chk("drain_data", got[j], 16'(j + 1));
        chk("drain_valid", Res_Valid_a, 0);

        // Unsupported code
        step(0, 1, 9, 16'd7, 0);
        chk("err_flag", Err_a, 1);
        chk("err_busy", Busy_a, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 9, 16'd7, 0);
        chk("err_nopush", Res_Valid_a, 0);

        // Restart during CAPTURE
        step(0, 1, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 5, 1);
        step(0, 0, 1, 6, 1);
        step(0, 0, 1, 7, 1);
        step(0, 1, 1, 0, 0);
        chk("restart_valid", Res_Valid_a, 0);
        chk("restart_cks", Checksum_a, 0);
        chk("restart_busy", Busy_a, 1);
        got.delete();
        for (int i = 1; i < 14; i++) step(0, 0, 1, (i < 2) ? 16'd0 : 16'(i - 1), 1);
        chk("restart_count", got.size(), 8);
        for (int j = 0; j < 8 && j < got.size(); j++) chk("restart_data", got[j], 16'(j + 1));
        chk("restart_sum", Checksum_a, 36);

        // Reset mid-FILL, reset beats a simultaneous Start_In
        step(0, 1, 2, 3, 0);
        step(0, 0, 2, 4, 0);
        step(1, 1, 2, 5, 1);
        chk("rfill_busy", Busy_a, 0);
        chk("rfill_data", Res_Data_a, 0);
        chk("rfill_valid", Res_Valid_a, 0);
        chk("rfill_cks", Checksum_a, 0);
        chk("rfill_err", Err_a, 0);
        step(0, 0, 2, 6, 0);
        chk("rfill_idle", Busy_a, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            bit st, rs;
            rs = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 14) == 0);
            step(rs, st, 16'($urandom_range(0, 10)), 16'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pe_result_collector.md
# pe_result_collector

Downstream companion to the M216A processing element. It consumes the PE's `D_Out` stream and the same `Instruction_In` word the PE is running. It discards the function-dependent pipeline-fill samples, then captures a fixed-length window of valid results into a first-word-fall-through FIFO. It also keeps a running checksum, so results can be drained by a valid/ready consumer and runs can be checked without cycle-exact alignment.

## Interface
- `RUN_LEN`, 8: number of valid results captured per run (1..255).
- `FIFO_DEPTH`, 8: result FIFO entries (power of two, ≥2).

Ports:
- `Clk_In` in 1: single clock, all state updates on its rising edge.
- `Rst_In` in 1: reset, synchronous, active-high.
- `Instruction_In` in 16: function code driven to the PE; latched on `Start_In`.
- `Start_In` in 1: one-cycle pulse marking the first cycle the PE is out of reset for a new run.
- `D_Out_In` in 16: PE `D_Out`.
- `Res_Data` out 16: FIFO head (valid when `Res_Valid`).
- `Res_Valid` out 1: FIFO not empty.
- `Res_Ready` in 1: consumer accepts head this cycle.
- `Busy` out 1: state is FILL or CAPTURE.
- `Done` out 1: window complete; level, held until next `Start_In`/reset.
- `Checksum` out 32: sum of all in-window samples, mod 2^32.
- `Overflow` out 1: sticky; an in-window sample was dropped because the FIFO was full.
- `Err_Out` out 1: sticky; `Start_In` seen with an unsupported instruction.

## Operation
- Latency L is decoded from `Instruction_In[15:0]` at `Start_In`:
  - codes 1, 3, 4, 5, 6 → 2
  - codes 2, 7 → 4
  - code 8 → 6
  - any other code is unsupported.
- States:
  - IDLE: wait for `Start_In`.
  - FILL: discard L samples.
  - CAPTURE: capture `RUN_LEN` samples.
  - DONE: `Done`=1; wait for `Start_In`.
- `Start_In` is accepted in every state, including mid-run. On acceptance:
  - FIFO flushed; `Checksum`, `Overflow`, `Err_Out`, `Done` cleared.
  - Instruction latched; sample counter reset.
  - If the code is supported, go to FILL. Otherwise set `Err_Out` and go to IDLE.
- Sample indexing: the `D_Out_In` value at the edge where `Start_In` is sampled high is index 0.
  - Indices 0..L-1 are discarded (FILL).
  - Indices L..L+RUN_LEN-1 are in-window (CAPTURE).
  - After the last in-window index: CAPTURE→DONE.
- Each in-window sample:
  - is added to `Checksum` (zero-extended, wraps);
  - is pushed to the FIFO if there is room;
  - if the FIFO is full and no pop occurs that cycle, the sample is dropped and `Overflow` is set.
- Push and pop in the same cycle:
  - legal in every FIFO occupancy state, including full; occupancy is unchanged.
  - Push/pop on an empty FIFO does not bypass: the pushed data appears on `Res_Data` the next cycle.
- Pop occurs when `Res_Valid & Res_Ready`; `Res_Ready` while empty is ignored.
- The FIFO keeps draining in IDLE and DONE; only `Start_In` or reset clears it.
- Reset values: state IDLE, FIFO empty, all outputs 0 (`Res_Data` 0).
- Reset overrides `Start_In` in the same cycle. Reset mid-run discards FIFO contents and checksum.

## Timing
- `Res_Valid` rises the cycle after the first push (one-cycle FIFO latency).
- `Busy` rises the cycle after `Start_In` and falls the cycle after the last in-window sample, when `Done` rises.
- `Checksum` after a run is final the cycle `Done` rises.
- Minimum `Start_In`→`Done` is L+RUN_LEN cycles.
- `Overflow`/`Err_Out` update the cycle after the causing edge.
- No combinational path from `Res_Ready` to `Res_Valid`/`Res_Data`.

## Test plan
- **Function 1:** `D_Out_In` = 0,0,1,2,…,9; `RUN_LEN`=8; `Res_Ready`=1.
  - `Res_Data` stream: 1..8.
  - `Checksum`=36, `Done`=1, `Overflow`=0.
- **Function 2:** stream 0,0,0,0,1..8.
  - Discards 4 samples; captures 1..8; `Checksum`=36.
- **Function 3:** stream 0,0,12,14,…,26.
  - Captures 12,14,…,26; `Checksum`=152.
- **Function 8:** `RUN_LEN`=5; stream 0,0,0,0,0,0,12,32,62,104,160.
  - Captures the last five values; `Checksum`=370.
- **Overflow:** `FIFO_DEPTH`=4, `Res_Ready`=0, function 1 stream.
  - FIFO holds 1,2,3,4; `Overflow`=1; `Checksum`=36.
  - Then assert `Res_Ready`: 1..4 drain and `Res_Valid` falls.
- **Errors and restarts:**
  - `Start_In` with code 9: `Err_Out`=1, state IDLE, no pushes.
  - `Start_In` during CAPTURE: FIFO flushes and the window restarts.
  - `Rst_In` mid-FILL: all outputs return to 0.
